mac_stream_acc: RTL and testbench
=================================

Name: mac_stream_acc

Overview:
Streaming, pipelined integer dot-product engine; successor to the combinational mac_full datapath.
- Accepts a job of LEN packed value/weight beats over a valid/ready handshake.
- Multiplies packed signed lanes (INT4 x4, INT8 x2, INT16 x1) per beat, adds a per-job bias, and accumulates with saturation.
- Returns one result per job over a valid/ready output handshake.
- Sits between operand buffers and the requant/activation stage. FP16 stays in mac_full.

Parameters:
DW, 16, packed operand width; must be a multiple of 16.
ACCW, 32, accumulator/result width (signed); must be at least 2*DW.
LEN_W, 8, width of job length field; max job = 2^LEN_W-1 beats.

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  job request, sampled only in IDLE.
mode  input  3  one-hot: bit0 INT4, bit1 INT8, bit2 INT16; latched at start.
len  input  LEN_W  beats in job; latched at start.
bias  input  ACCW  signed initial accumulator value; latched at start.
in_valid  input  1  beat valid.
in_ready  output  1  beat accepted when in_valid&&in_ready.
value  input  DW  packed signed activation lanes.
weight  input  DW  packed signed weight lanes.
out_valid  output  1  result valid.
out_ready  input  1  result consumed when out_valid&&out_ready.
result  output  ACCW  saturated signed dot product + bias.
ovf  output  1  sticky saturation flag for the job; valid with out_valid.
busy  output  1  high in any state other than IDLE.
err  output  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset: synchronous, active-high, on rst sampled high at a clk edge. Values after reset:
  - state=IDLE.
  - in_ready=0, out_valid=0, result=0, ovf=0, busy=0, err=0.
  - Pipeline valid bits cleared.
  - rst mid-job discards the job. No partial result is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - If start=1 and mode is not exactly one-hot, or len=0: err=1 for one cycle, stay IDLE.
  - Else latch mode and len, set acc=bias, cnt=0, ovf=0, and go to RUN.
  - start in any other state is ignored, with no err.
- RUN:
  - in_ready = (cnt<len); this is a registered compare.
  - Each accepted beat increments cnt.
  - Gaps on in_valid are allowed.
  - Go to DRAIN on the edge that accepts beat number len. in_ready is 0 from the next cycle.
- DRAIN: wait until both pipeline stages are empty, then go to DONE with out_valid=1.
- DONE:
  - result and ovf are held stable while out_ready=0.
  - On handshake: out_valid drops and the FSM returns to IDLE.
  - A start in that same cycle is not accepted. Earliest new start is the following cycle.
- Pipeline:
  - S1 (registered on accept): lane products and their sum, sign-extended to ACCW.
    - Per 16-bit slice, INT4: sum of 4 products of signed 4-bit lanes [4k+3:4k].
    - Per 16-bit slice, INT8: sum of 2 products of signed 8-bit lanes.
    - Per 16-bit slice, INT16: 1 signed 16x16 product.
    - For DW>16, the slice sums are added together.
  - S2: acc <= sat(acc + s1_sum), computed at ACCW+1 bits.
    - Clamps to +2^(ACCW-1)-1 / -2^(ACCW-1).
    - Any clamp sets ovf. ovf stays set for the job.
    - Later beats continue from the clamped value.
- Latency: out_valid rises 3 edges after the edge accepting the last beat (S1, S2, DONE register). Throughput is 1 beat/clk.
- Full-length boundaries: len=2^LEN_W-1 must count without wrap. cnt is LEN_W bits and is never incremented past len.

Test Plan:
- INT8, bias=100, len=1, value=16'h7F80, weight=16'h0203 -> 127*2 + (-128)*3 + 100 = -30; result=32'hFFFFFFE2, ovf=0, out_valid 3 edges after accept.
- INT4, bias=0, len=3, value=16'h1234 and weight=16'h1111 each beat, with one idle cycle between beats -> result=30 (32'h1E), in_ready low after beat 3.
- INT16, bias=0, len=2, value=weight=16'h8000 -> after beat 1 acc=32'h40000000; beat 2 saturates: result=32'h7FFFFFFF, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE -> result stable, busy=1; start pulses ignored with err=0; after handshake, IDLE; start accepted the next cycle.
- start with mode=3'b011, and separately with len=0 -> err pulses for 1 cycle, busy stays 0, no output.
- Assert rst after 2 of 4 beats of an INT8 job -> all outputs 0 the next cycle; a fresh job (len=1, bias=5, value=weight=16'h0101) -> result=7.

Source files
------------

// File: rtl/mac_stream_acc.sv
// mac_stream_acc: streaming packed-lane integer dot product with bias, saturating accumulate and valid/ready I/O
module mac_stream_acc #(
   parameter int DW    = 16,
   parameter int ACCW  = 32,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [LEN_W-1:0] len,
   input  logic [ACCW-1:0]  bias,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    value,
   input  logic [DW-1:0]    weight,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACCW-1:0]  result,
   output logic             ovf,
   output logic             busy,
   output logic             err
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;
   logic [2:0] mode_r;
   logic [LEN_W-1:0] len_r, cnt, cnt_inc;
   logic [ACCW-1:0] acc, s1_sum, prod_sum, acc_next;
   logic [ACCW:0] sum_x;
   logic s1_v, s2_v, accept, last, bad, sat;
   always_comb begin
      prod_sum = '0;
      for (int s = 0; s < DW/16; s++) begin
         if (mode_r[0])
            for (int k = 0; k < 4; k++)
               prod_sum = prod_sum + ACCW'($signed(value[s*16+k*4 +: 4]) * $signed(weight[s*16+k*4 +: 4]));
         if (mode_r[1])
            for (int k = 0; k < 2; k++)
               prod_sum = prod_sum + ACCW'($signed(value[s*16+k*8 +: 8]) * $signed(weight[s*16+k*8 +: 8]));
         if (mode_r[2])
            prod_sum = prod_sum + ACCW'($signed(value[s*16 +: 16]) * $signed(weight[s*16 +: 16]));
      end
   end
   assign sum_x    = {acc[ACCW-1], acc} + {s1_sum[ACCW-1], s1_sum};
   assign sat      = sum_x[ACCW] != sum_x[ACCW-1];
   assign acc_next = !sat ? sum_x[ACCW-1:0] : sum_x[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
   assign cnt_inc  = cnt + 1'b1;
   assign accept   = in_valid && in_ready;
   assign last     = accept && cnt_inc == len_r;
   assign bad      = !(mode == 3'b001 || mode == 3'b010 || mode == 3'b100) || len == '0;
   assign busy     = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mode_r    <= '0;
         len_r     <= '0;
         cnt       <= '0;
         acc       <= '0;
         s1_sum    <= '0;
         s1_v      <= 1'b0;
         s2_v      <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         err       <= 1'b0;
      end else begin
         err  <= state == IDLE && start && bad;
         s1_v <= accept;
         s2_v <= s1_v;
         if (accept) begin
            s1_sum   <= prod_sum;
            cnt      <= cnt_inc;
            in_ready <= cnt_inc != len_r;
         end
         if (s1_v) begin
            acc <= acc_next;
            ovf <= ovf | sat;
         end
         case (state)
            IDLE: if (start && !bad) begin
               mode_r   <= mode;
               len_r    <= len;
               acc      <= bias;
               cnt      <= '0;
               ovf      <= 1'b0;
               in_ready <= 1'b1;
               state    <= RUN;
            end
            RUN: if (last) state <= DRAIN;
            DRAIN: if (!s1_v && !s2_v) begin
               state     <= DONE;
               out_valid <= 1'b1;
               result    <= acc;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_stream_acc.sv
// tb_mac_stream_acc: random and directed jobs checked against an arithmetic dot-product model
module tb_mac_stream_acc;
   logic clk = 1'b0, rst, start, in_valid, in_ready, out_valid, out_ready, ovf, busy, err;
   logic [2:0] mode;
   logic [7:0] len;
   logic [31:0] bias, result;
   logic [15:0] value, weight;
   logic [15:0] vq[$], wq[$];
   int checks = 0, errors = 0;
   localparam longint MAXV = (64'sd1 <<< 31) - 1;
   localparam longint MINV = -(64'sd1 <<< 31);

   mac_stream_acc dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready), .value(value), .weight(weight),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic longint dot(input logic [2:0] m, input logic [15:0] v, input logic [15:0] w);
      int n, bits;
      longint s, a, b, mask;
      n = m[0] ? 4 : m[1] ? 2 : 1;
      bits = 16 / n;
      mask = (longint'(1) << bits) - 1;
      s = 0;
      for (int i = 0; i < n; i++) begin
         a = (longint'(v) >> (i*bits)) & mask;
         b = (longint'(w) >> (i*bits)) & mask;
         if (a > mask/2) a -= mask + 1;
         if (b > mask/2) b -= mask + 1;
         s += a * b;
      end
      return s;
   endfunction

   task automatic model(input logic [2:0] m, input logic [31:0] b, output logic [31:0] r, output logic o);
      longint a;
      a = longint'($signed(b));
      o = 1'b0;
      foreach (vq[i]) begin
         a += dot(m, vq[i], wq[i]);
         if (a > MAXV) begin a = MAXV; o = 1'b1; end
         else if (a < MINV) begin a = MINV; o = 1'b1; end
      end
      r = a[31:0];
   endtask

   task automatic fill(input int l);
      vq.delete();
      wq.delete();
      for (int i = 0; i < l; i++) begin
         vq.push_back(16'($urandom));
         wq.push_back(16'($urandom));
      end
   endtask

   task automatic do_start(input logic [2:0] m, input int l, input logic [31:0] b);
      start = 1'b1; mode = m; len = 8'(l); bias = b;
      step();
      start = 1'b0;
      chk("busy_start", {31'b0, busy}, 1);
      chk("err_start", {31'b0, err}, 0);
      chk("rdy_start", {31'b0, in_ready}, 1);
   endtask

   task automatic feed(input int gaps);
      int t;
      for (int b = 0; b < vq.size(); b++) begin
         if ((gaps == 1 && b > 0) || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            step();
         end
         value = vq[b]; weight = wq[b]; in_valid = 1'b1;
         t = 0;
         while (!in_ready && t < 10) begin step(); t++; end
         if (t == 10) chk("rdy_timeout", {31'b0, in_ready}, 1);
         step();
      end
      in_valid = 1'b0;
      chk("rdy_low_after_last", {31'b0, in_ready}, 0);
   endtask

   task automatic collect(input logic [31:0] er, input logic eo, input int hold, input bit spam);
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin step(); lat++; end
      chk("latency", lat, 3);
      chk("result", result, er);
      chk("ovf", {31'b0, ovf}, {31'b0, eo});
      for (int h = 0; h < hold; h++) begin
         start = spam; mode = 3'b011; len = 8'd1;
         step();
         chk("hold_res", result, er);
         chk("hold_valid", {31'b0, out_valid}, 1);
         chk("hold_busy", {31'b0, busy}, 1);
         chk("hold_err", {31'b0, err}, 0);
      end
      start = spam; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("hs_valid", {31'b0, out_valid}, 0);
      chk("hs_busy", {31'b0, busy}, 0);
      chk("hs_err", {31'b0, err}, 0);
   endtask

   task automatic job(input logic [2:0] m, input int l, input logic [31:0] b, input int gaps, input int hold, input bit spam);
      logic [31:0] er;
      logic eo;
      model(m, b, er, eo);
      do_start(m, l, b);
      feed(gaps);
      collect(er, eo, hold, spam);
   endtask

   task automatic bad_start(input logic [2:0] m, input int l);
      start = 1'b1; mode = m; len = 8'(l);
      step();
      start = 1'b0;
      chk("bad_err", {31'b0, err}, 1);
      chk("bad_busy", {31'b0, busy}, 0);
      step();
      chk("bad_err_pulse", {31'b0, err}, 0);
      chk("bad_busy2", {31'b0, busy}, 0);
      chk("bad_valid", {31'b0, out_valid}, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rdy"}, {31'b0, in_ready}, 0);
      chk({tag, "_valid"}, {31'b0, out_valid}, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_ovf"}, {31'b0, ovf}, 0);
      chk({tag, "_busy"}, {31'b0, busy}, 0);
      chk({tag, "_err"}, {31'b0, err}, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      value = '0; weight = '0; mode = 3'b001; len = 8'd1; bias = '0;
      step();
      step();
      chk_zero("reset");
      rst = 1'b0;
      step();
      vq = '{16'h7F80}; wq = '{16'h0203};
      job(3'b010, 1, 32'd100, 0, 0, 1'b0);
      chk("tp_int8", result, 32'hFFFFFFE2);
      vq = '{16'h1234, 16'h1234, 16'h1234}; wq = '{16'h1111, 16'h1111, 16'h1111};
      job(3'b001, 3, 32'd0, 1, 0, 1'b0);
      chk("tp_int4", result, 32'h1E);
      vq = '{16'h8000, 16'h8000}; wq = '{16'h8000, 16'h8000};
      job(3'b100, 2, 32'd0, 0, 0, 1'b0);
      chk("tp_int16_sat", result, 32'h7FFFFFFF);
      chk("tp_int16_ovf", {31'b0, ovf}, 1);
      fill(2);
      job(3'b010, 2, 32'd7, 0, 5, 1'b1);
      fill(1);
      job(3'b100, 1, 32'hFFFFFF00, 0, 0, 1'b0);
      bad_start(3'b011, 1);
      bad_start(3'b001, 0);
      bad_start(3'b000, 4);
      fill(4);
      do_start(3'b010, 4, 32'd0);
      for (int b = 0; b < 2; b++) begin
         value = vq[b]; weight = wq[b]; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      chk_zero("midrst");
      rst = 1'b0;
      step();
      vq = '{16'h0101}; wq = '{16'h0101};
      job(3'b010, 1, 32'd5, 0, 0, 1'b0);
      chk("tp_after_rst", result, 32'd7);
      for (int j = 0; j < 40; j++) begin
         logic [2:0] m;
         logic [31:0] b;
         int l;
         m = 3'(1 << $urandom_range(0, 2));
         l = $urandom_range(1, 6);
         case ($urandom_range(0, 2))
            0: b = $urandom;
            1: b = 32'h7FFF0000 + 32'($urandom_range(0, 65535));
            default: b = 32'h80000000 + 32'($urandom_range(0, 65535));
         endcase
         fill(l);
         job(m, l, b, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      fill(255);
      job(3'b001, 255, 32'd0, 0, 1, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
